brent_kung_cin: RTL and testbench
=================================

// Module: brent_kung_cin
// PURPOSE
//  Registered unsigned adder built on a Brent-Kung parallel-prefix carry tree, with carry-in.
//  Computes out = a + b + cin at WIDTH+1 bits; the MSB of out is the carry-out.
//  Leaf arithmetic block for datapaths that need log-depth carry logic with a registered result.
// PARAMETERS
//  WIDTH  4  operand width; power of two, 2..64; elaboration error otherwise
// PORTS
//  clk    in   1        single clock; all state on rising edge
//  rst_n  in   1        asynchronous active-low reset
//  out    out  WIDTH+1  registered sum; out[WIDTH] = carry-out, out[WIDTH-1:0] = sum bits
//  a      in   WIDTH    operand A, unsigned
//  b      in   WIDTH    operand B, unsigned
//  cin    in   1        carry-in
// BEHAVIOUR
//  - Reset: rst_n low forces out = 0 immediately (async), held while low; no other state.
//  - Latency 1: out at edge k+1 = a+b+cin sampled at edge k; new result every cycle, no handshake.
//  - Arithmetic: exact unsigned sum, no truncation; max (2^WIDTH-1)*2+1 fits WIDTH+1 bits.
//  - Bit gen/prop: g[i]=a[i]&b[i], p[i]=a[i]^b[i]; cin folded into bit 0 group: G0 = g[0] | p[0]&cin.
//  - Prefix op (g_hi,p_hi)o(g_lo,p_lo) = (g_hi | p_hi&g_lo, p_hi&p_lo).
//  - Up-sweep: log2(WIDTH) levels; level l combines node i with i-2^(l-1) for i = k*2^l-1.
//  - Down-sweep: log2(WIDTH)-1 levels filling the remaining odd-span prefixes.
//  - Carries: c[0]=cin, c[i+1]=G[i:0]; sum[i]=p[i]^c[i]; out[WIDTH]=c[WIDTH].
//  - Prefix logic purely combinational between input pins and out register; no latches.
//  - Reset release: first rising edge after rst_n rises captures current inputs; no warm-up.
//  - X on any input may propagate to out; no X-masking required.
// CONFIGURATION
//  BRENT_KUNG_IN_REG_EN defined: a, b, cin are first registered (async reset to 0), then the
//   prefix tree feeds the out register; latency 2 cycles, reset clears both stages.
//  Not defined: no input stage, latency 1 cycle as above.
// STRUCTURE
//  Package bk_pkg: typedef struct packed {logic g; logic p;} bk_gp_t; function bk_clog2;
//   localparam BK_MAX_WIDTH = 64.
//  Sub-module bk_gp_cell: one prefix operator (inputs hi/lo bk_gp_t, output bk_gp_t);
//   tree instantiated by generate loops over up-sweep and down-sweep levels.
//  Top: gen/prop layer, cin fold, tree, sum XOR layer, output register (+ optional input register).
// TESTING  (WIDTH=4, macro off; check out one cycle after applying inputs)
//  1. rst_n=0 with a=5,b=3,cin=1 -> out=5'b00000 immediately; held until release.
//  2. a=0,b=0,cin=0 -> out=5'b00000; then a=2 -> 5'b00010.
//  3. a=2,b=1,cin=0 -> 5'b00011; then cin=1 -> 5'b00100.
//  4. a=15,b=0,cin=1 -> 5'b10000 (full carry ripple through tree); a=15,b=15,cin=1 -> 5'b11111.
//  5. Exhaustive 512 combos of a,b,cin vs a+b+cin, back-to-back each cycle -> no mismatch.
//  6. Assert rst_n mid-stream -> out=0 asynchronously; after release next edge shows live sum;
//     repeat 5 with BRENT_KUNG_IN_REG_EN defined -> results 2 cycles after inputs.

Source files
------------

// File: rtl/bk_pkg.sv
// rtl/bk_pkg.sv - shared types and helpers for the Brent-Kung carry-in adder
package bk_pkg;

    localparam int BK_MAX_WIDTH = 64;

    typedef struct packed {
        logic g;
        logic p;
    } bk_gp_t;

    function automatic int bk_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/bk_gp_cell.sv
// rtl/bk_gp_cell.sv - single Brent-Kung prefix operator (hi o lo)
module bk_gp_cell
    import bk_pkg::*;
(
    input  bk_gp_t hi,
    input  bk_gp_t lo,
    output bk_gp_t o
);

    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = hi.p & lo.p;

endmodule

// File: rtl/brent_kung_cin.sv
// rtl/brent_kung_cin.sv - registered Brent-Kung adder with carry-in; BRENT_KUNG_IN_REG_EN adds an input register stage
module brent_kung_cin
    import bk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH:0]   out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin
);

    localparam int LEVELS = bk_clog2(WIDTH);
    localparam int STAGES = 2 * LEVELS;

    if ((WIDTH < 2) || (WIDTH > BK_MAX_WIDTH) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $error("brent_kung_cin: WIDTH must be a power of two in 2..64");
    end

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic             cin_s;

`ifdef BRENT_KUNG_IN_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s   <= '0;
            b_s   <= '0;
            cin_s <= 1'b0;
        end else begin
            a_s   <= a;
            b_s   <= b;
            cin_s <= cin;
        end
    end
`else
    assign a_s   = a;
    assign b_s   = b;
    assign cin_s = cin;
`endif

    logic   [WIDTH-1:0] p;
    bk_gp_t [WIDTH-1:0] leaf;

    assign p = a_s ^ b_s;

    // Carry-in is absorbed into bit 0, so every prefix G[i:0] is already the carry into bit i+1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
        if (i == 0) begin : g_fold
            assign leaf[i].g = (a_s[i] & b_s[i]) | (p[i] & cin_s);
        end else begin : g_plain
            assign leaf[i].g = a_s[i] & b_s[i];
        end
        assign leaf[i].p = p[i];
    end

    // Stages 1..LEVELS are the up-sweep, the rest the down-sweep (span halving each stage).
    for (genvar s = 1; s < STAGES; s++) begin : g_stage
        localparam int D = 2 * LEVELS - s;
        localparam int DIST = (s <= LEVELS) ? (1 << (s - 1)) : (1 << (D - 1));

        bk_gp_t [WIDTH-1:0] prev;
        bk_gp_t [WIDTH-1:0] row;

        if (s == 1) begin : g_from_leaf
            assign prev = leaf;
        end else begin : g_from_stage
            assign prev = g_stage[s-1].row;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            localparam bit COMB = (s <= LEVELS)
                ? (((i + 1) % (1 << s)) == 0)
                : ((i >= (1 << D)) && (((i + 1 - (1 << (D - 1))) % (1 << D)) == 0));

            if (COMB) begin : g_op
                bk_gp_cell u_cell (
                    .hi (prev[i]),
                    .lo (prev[i-DIST]),
                    .o  (row[i])
                );
            end else begin : g_pass
                assign row[i] = prev[i];
            end
        end
    end

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] unused_final_p;

    assign c[0] = cin_s;
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign c[i+1]            = g_stage[STAGES-1].row[i].g;
        assign unused_final_p[i] = g_stage[STAGES-1].row[i].p;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= {c[WIDTH], p ^ c[WIDTH-1:0]};
        end
    end

endmodule

// File: tb/tb_brent_kung_cin.sv
// tb/tb_brent_kung_cin.sv - self-checking bench for brent_kung_cin (honours BRENT_KUNG_IN_REG_EN)
module tb_brent_kung_cin;

    localparam int WIDTH = 4;
`ifdef BRENT_KUNG_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             cin   = 1'b0;
    logic [WIDTH:0]   out;

    int errors = 0;
    int checks = 0;

    brent_kung_cin #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .out   (out),
        .a     (a),
        .b     (b),
        .cin   (cin)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH:0] ref_sum(input int unsigned x, input int unsigned y, input int unsigned c);
        int unsigned total;
        total = x + y + c;
        return total[WIDTH:0];
    endfunction

    task automatic apply(input int unsigned x, input int unsigned y, input int unsigned c);
        a   = x[WIDTH-1:0];
        b   = y[WIDTH-1:0];
        cin = c[0];
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        a = 4'd5; b = 4'd3; cin = 1'b1;
        #1;
        checks++;
        if (out !== 5'b00000) begin
            errors++;
            $display("FAIL reset_immediate: got %b want 00000", out);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out !== 5'b00000) begin
                errors++;
                $display("FAIL reset_held[%0d]: got %b want 00000", k, out);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        checks++;
        if (out !== 5'd9) begin
            errors++;
            $display("FAIL reset_release: got %b want 01001", out);
        end
    endtask

    task automatic test_directed;
        int unsigned tbl [8][4] = '{
            '{0, 0, 0, 5'b00000}, '{2, 0, 0, 5'b00010},
            '{2, 1, 0, 5'b00011}, '{2, 1, 1, 5'b00100},
            '{15, 0, 1, 5'b10000}, '{15, 15, 1, 5'b11111},
            '{15, 15, 0, 5'b11110}, '{0, 15, 1, 5'b10000}
        };
        for (int k = 0; k < 8; k++) begin
            apply(tbl[k][0], tbl[k][1], tbl[k][2]);
            checks++;
            if (out !== tbl[k][3][WIDTH:0]) begin
                errors++;
                $display("FAIL directed[%0d] a=%0d b=%0d cin=%0d: got %b want %b",
                         k, tbl[k][0], tbl[k][1], tbl[k][2], out, tbl[k][3][WIDTH:0]);
            end
        end
    endtask

    task automatic run_stream(input string name, input int n, input bit exhaustive);
        logic [WIDTH:0] q[$];
        logic [WIDTH:0] exp_v;
        logic [8:0]     combo;
        for (int k = 0; k < n; k++) begin
            combo = exhaustive ? k[8:0] : 9'($urandom);
            {cin, b, a} = combo;
            q.push_back(ref_sum(a, b, cin));
            @(posedge clk); #1;
            if (q.size() == LAT) begin
                exp_v = q.pop_front();
                checks++;
                if (out !== exp_v) begin
                    errors++;
                    $display("FAIL %s[%0d]: got %b want %b", name, k, out, exp_v);
                end
            end
        end
        while (q.size() > 0) begin
            @(posedge clk); #1;
            exp_v = q.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL %s_drain: got %b want %b", name, out, exp_v);
            end
        end
    endtask

    task automatic test_exhaustive;
        run_stream("exhaustive", 512, 1'b1);
    endtask

    task automatic test_random;
        run_stream("random", 300, 1'b0);
    endtask

    task automatic test_midstream_reset;
        apply(15, 15, 1);
        checks++;
        if (out !== 5'b11111) begin
            errors++;
            $display("FAIL mid_pre: got %b want 11111", out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 5'b00000) begin
            errors++;
            $display("FAIL mid_async: got %b want 00000", out);
        end
        @(posedge clk); #1;
        checks++;
        if (out !== 5'b00000) begin
            errors++;
            $display("FAIL mid_held: got %b want 00000", out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'd7; b = 4'd6; cin = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        checks++;
        if (out !== ref_sum(7, 6, 1)) begin
            errors++;
            $display("FAIL mid_release: got %b want %b", out, ref_sum(7, 6, 1));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exhaustive();
        test_random();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
